// File: rtl/traffic_injector_if.sv
// Packet channel between a traffic_injector and one network-core edge port.
//   master : injector side, drives the packet fields and out_valid, samples out_ready
//   slave  : port side, samples the packet, drives out_ready
interface traffic_injector_if #(
   parameter int unsigned X_ADDR_WIDTH = 3,
   parameter int unsigned Y_ADDR_WIDTH = 3,
   parameter int unsigned SERIAL_WIDTH = 16
);
   logic                    out_valid;
   logic                    out_ready;
   logic [X_ADDR_WIDTH-1:0] out_dest_x;
   logic [Y_ADDR_WIDTH-1:0] out_dest_y;
   logic [X_ADDR_WIDTH-1:0] out_gate_x;
   logic [Y_ADDR_WIDTH-1:0] out_gate_y;
   logic [SERIAL_WIDTH-1:0] out_serial;
   logic [7:0]              out_src_id;

   modport master (
      output out_valid, out_dest_x, out_dest_y, out_gate_x, out_gate_y,
             out_serial, out_src_id,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_dest_x, out_dest_y, out_gate_x, out_gate_y,
             out_serial, out_src_id,
      output out_ready
   );
endinterface

// File: rtl/traffic_injector.sv
// Packet-traffic generator for one edge input port of the network core.
// Walks a programmable destination/gate table, throttles issue to rate_num slots
// per RATE_DEN-cycle window, stamps per-run serials and holds each packet until
// the port accepts it.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   tbl_we/tbl_addr/tbl_* table write port (honoured outside RUN only)
//   start                 one-cycle run start; samples pkt_total, rate_num,
//                         phase_init, tbl_start, lfsr_seed
//   pkt_if (master)       packet channel: valid/ready, addresses, serial, src id
//   busy, done            state == RUN / state == DONE
//   sent_count            packets accepted this run
//   stall_count           cycles with out_valid & !out_ready (saturating)
// Build option: TRAFFIC_INJECTOR_LFSR_EN selects table entries via a 16-bit LFSR
// (seeded from lfsr_seed) instead of the sequential walk from tbl_start.
module traffic_injector #(
   parameter int unsigned X_ADDR_WIDTH = 3,
   parameter int unsigned Y_ADDR_WIDTH = 3,
   parameter int unsigned SERIAL_WIDTH = 16,
   parameter int unsigned TABLE_DEPTH  = 10,
   parameter int unsigned RATE_DEN     = 10,
   parameter int unsigned SRC_ID       = 0
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic                                                tbl_we,
   input  logic [$clog2(TABLE_DEPTH)-1:0]                      tbl_addr,
   input  logic [X_ADDR_WIDTH-1:0]                             tbl_dest_x,
   input  logic [Y_ADDR_WIDTH-1:0]                             tbl_dest_y,
   input  logic [X_ADDR_WIDTH-1:0]                             tbl_gate_x,
   input  logic [Y_ADDR_WIDTH-1:0]                             tbl_gate_y,
   input  logic                                                start,
   input  logic [SERIAL_WIDTH-1:0]                             pkt_total,
   input  logic [$clog2(RATE_DEN+1)-1:0]                       rate_num,
   input  logic [((RATE_DEN > 1) ? $clog2(RATE_DEN) : 1)-1:0]  phase_init,
   input  logic [$clog2(TABLE_DEPTH)-1:0]                      tbl_start,
   input  logic [15:0]                                         lfsr_seed,
   traffic_injector_if.master                                  pkt_if,
   output logic                                                busy,
   output logic                                                done,
   output logic [SERIAL_WIDTH-1:0]                             sent_count,
   output logic [SERIAL_WIDTH-1:0]                             stall_count
);

   localparam int unsigned AW = $clog2(TABLE_DEPTH);
   localparam int unsigned RW = $clog2(RATE_DEN + 1);
   localparam int unsigned PW = (RATE_DEN > 1) ? $clog2(RATE_DEN) : 1;
   localparam int unsigned SW = SERIAL_WIDTH;
   localparam int unsigned XW = X_ADDR_WIDTH;
   localparam int unsigned YW = Y_ADDR_WIDTH;
   localparam logic [AW-1:0] LAST_IDX = AW'(TABLE_DEPTH - 1);
   localparam logic [PW-1:0] LAST_PH  = PW'(RATE_DEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [SW-1:0]   issued_q, issued_d;
   logic [SW-1:0]   sent_q, sent_d;
   logic [SW-1:0]   stall_q, stall_d;
   logic [SW-1:0]   pkt_total_q, pkt_total_d;
   logic [RW-1:0]   rate_num_q, rate_num_d;
   logic            valid_q, valid_d;
   logic [XW-1:0]   dest_x_q, dest_x_d, gate_x_q, gate_x_d;
   logic [YW-1:0]   dest_y_q, dest_y_d, gate_y_q, gate_y_d;
   logic [SW-1:0]   serial_q, serial_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [AW-1:0]   idx_c;
   logic            xfer_c;
   logic            unused_c;

   logic [XW-1:0]   tdx_q [TABLE_DEPTH];
   logic [XW-1:0]   tdx_d [TABLE_DEPTH];
   logic [YW-1:0]   tdy_q [TABLE_DEPTH];
   logic [YW-1:0]   tdy_d [TABLE_DEPTH];
   logic [XW-1:0]   tgx_q [TABLE_DEPTH];
   logic [XW-1:0]   tgx_d [TABLE_DEPTH];
   logic [YW-1:0]   tgy_q [TABLE_DEPTH];
   logic [YW-1:0]   tgy_d [TABLE_DEPTH];

`ifdef TRAFFIC_INJECTOR_LFSR_EN
   logic [15:0]     lfsr_q, lfsr_d;
   logic [15:0]     lfsr_next_c;
   assign lfsr_next_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign idx_c       = AW'(lfsr_q % 16'(TABLE_DEPTH));
   assign unused_c    = ^tbl_start;
`else
   logic [AW-1:0]   ptr_q, ptr_d;
   assign idx_c       = ptr_q;
   assign unused_c    = ^lfsr_seed;
`endif

   assign xfer_c = valid_q & pkt_if.out_ready;

   // Table write port; locked while a run is in progress.
   always_comb begin
      tdx_d = tdx_q;
      tdy_d = tdy_q;
      tgx_d = tgx_q;
      tgy_d = tgy_q;
      if (tbl_we && (state_q != ST_RUN) && (tbl_addr <= LAST_IDX)) begin
         tdx_d[tbl_addr] = tbl_dest_x;
         tdy_d[tbl_addr] = tbl_dest_y;
         tgx_d[tbl_addr] = tbl_gate_x;
         tgy_d[tbl_addr] = tbl_gate_y;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      issued_d    = issued_q;
      sent_d      = sent_q;
      stall_d     = stall_q;
      pkt_total_d = pkt_total_q;
      rate_num_d  = rate_num_q;
      valid_d     = valid_q;
      dest_x_d    = dest_x_q;
      dest_y_d    = dest_y_q;
      gate_x_d    = gate_x_q;
      gate_y_d    = gate_y_q;
      serial_d    = serial_q;
`ifdef TRAFFIC_INJECTOR_LFSR_EN
      lfsr_d      = lfsr_q;
`else
      ptr_d       = ptr_q;
`endif

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               pkt_total_d = pkt_total;
               rate_num_d  = rate_num;
               phase_d     = phase_init;
               issued_d    = '0;
               sent_d      = '0;
               stall_d     = '0;
`ifdef TRAFFIC_INJECTOR_LFSR_EN
               lfsr_d      = (lfsr_seed == 16'h0000) ? 16'hACE1 : lfsr_seed;
`else
               // An out-of-range start index would address no entry; start at 0.
               ptr_d       = (tbl_start <= LAST_IDX) ? tbl_start : '0;
`endif
            end
         end
         ST_RUN: begin
            // Window phase runs freely, regardless of backpressure.
            phase_d = (phase_q >= LAST_PH) ? '0 : phase_q + PW'(1);

            if (xfer_c) begin
               sent_d  = sent_q + SW'(1);
               valid_d = 1'b0;
            end
            if (valid_q && !pkt_if.out_ready && (stall_q != '1)) begin
               stall_d = stall_q + SW'(1);
            end

            // Issue into a free slot; a slot that lands on a stall is simply lost.
            if ((!valid_q || pkt_if.out_ready) && (RW'(phase_q) < rate_num_q) &&
                (issued_q < pkt_total_q)) begin
               valid_d  = 1'b1;
               dest_x_d = tdx_q[idx_c];
               dest_y_d = tdy_q[idx_c];
               gate_x_d = tgx_q[idx_c];
               gate_y_d = tgy_q[idx_c];
               serial_d = issued_q;
               issued_d = issued_q + SW'(1);
`ifdef TRAFFIC_INJECTOR_LFSR_EN
               lfsr_d   = lfsr_next_c;
`else
               ptr_d    = (ptr_q >= LAST_IDX) ? '0 : ptr_q + AW'(1);
`endif
            end

            if ((sent_q == pkt_total_q) && !valid_q) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // Control and packet registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         stall_q     <= '0;
         pkt_total_q <= '0;
         rate_num_q  <= '0;
         valid_q     <= 1'b0;
         dest_x_q    <= '0;
         dest_y_q    <= '0;
         gate_x_q    <= '0;
         gate_y_q    <= '0;
         serial_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef TRAFFIC_INJECTOR_LFSR_EN
         lfsr_q      <= 16'hACE1;
`else
         ptr_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         issued_q    <= issued_d;
         sent_q      <= sent_d;
         stall_q     <= stall_d;
         pkt_total_q <= pkt_total_d;
         rate_num_q  <= rate_num_d;
         valid_q     <= valid_d;
         dest_x_q    <= dest_x_d;
         dest_y_q    <= dest_y_d;
         gate_x_q    <= gate_x_d;
         gate_y_q    <= gate_y_d;
         serial_q    <= serial_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef TRAFFIC_INJECTOR_LFSR_EN
         lfsr_q      <= lfsr_d;
`else
         ptr_q       <= ptr_d;
`endif
      end
   end

   // Table storage has no reset so it survives reset and successive runs.
   always_ff @(posedge clk) begin
      tdx_q <= tdx_d;
      tdy_q <= tdy_d;
      tgx_q <= tgx_d;
      tgy_q <= tgy_d;
   end

   assign pkt_if.out_valid  = valid_q;
   assign pkt_if.out_dest_x = dest_x_q;
   assign pkt_if.out_dest_y = dest_y_q;
   assign pkt_if.out_gate_x = gate_x_q;
   assign pkt_if.out_gate_y = gate_y_q;
   assign pkt_if.out_serial = serial_q;
   assign pkt_if.out_src_id = 8'(SRC_ID);
   assign busy              = busy_q;
   assign done              = done_q;
   assign sent_count        = sent_q;
   assign stall_count       = stall_q;

endmodule

// File: tb/tb_traffic_injector.sv
// Self-checking bench for traffic_injector: directed scenarios plus randomized
// runs, checked against a transaction-level model of the packet stream.
module tb_traffic_injector;
   localparam int unsigned XW = 3, YW = 3, SW = 16, D = 10, DEN = 10, SID = 90;
   localparam int BUDGET = 3000;

   logic          clk = 1'b0;
   logic          reset;
   logic          tbl_we;
   logic [3:0]    tbl_addr;
   logic [2:0]    tbl_dest_x, tbl_dest_y, tbl_gate_x, tbl_gate_y;
   logic          start;
   logic [15:0]   pkt_total;
   logic [3:0]    rate_num;
   logic [3:0]    phase_init;
   logic [3:0]    tbl_start;
   logic [15:0]   lfsr_seed;
   logic          busy, done;
   logic [15:0]   sent_count, stall_count;

   traffic_injector_if #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .SERIAL_WIDTH(SW)) pkt_if ();

   traffic_injector #(
      .X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .SERIAL_WIDTH(SW),
      .TABLE_DEPTH(D), .RATE_DEN(DEN), .SRC_ID(SID)
   ) dut (
      .clk(clk), .reset(reset),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr),
      .tbl_dest_x(tbl_dest_x), .tbl_dest_y(tbl_dest_y),
      .tbl_gate_x(tbl_gate_x), .tbl_gate_y(tbl_gate_y),
      .start(start), .pkt_total(pkt_total), .rate_num(rate_num),
      .phase_init(phase_init), .tbl_start(tbl_start), .lfsr_seed(lfsr_seed),
      .pkt_if(pkt_if),
      .busy(busy), .done(done), .sent_count(sent_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model of the destination table.
   logic [2:0] m_dx [D];
   logic [2:0] m_dy [D];
   logic [2:0] m_gx [D];
   logic [2:0] m_gy [D];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic write_entry(input int idx, input logic [2:0] dx, dy, gx, gy);
      tbl_we = 1'b1; tbl_addr = 4'(idx);
      tbl_dest_x = dx; tbl_dest_y = dy; tbl_gate_x = gx; tbl_gate_y = gy;
      tick();
      tbl_we = 1'b0;
      if (idx < D) begin
         m_dx[idx] = dx; m_dy[idx] = dy; m_gx[idx] = gx; m_gy[idx] = gy;
      end
   endtask

   // One run. mode 0: ready always high (exact timing checked);
   // mode 1: random ready; mode 2: ready low for 3 cycles while serial 2 is offered.
   task automatic run(input int total, input int rate, input int ph, input int ts,
                      input int mode, input logic [15:0] seed, input string name);
      int exp_idx[$];
      int iss_edge[$];
      logic [15:0] l;
      int n, k_x, k_i, stalls, hold, exp_done;
      bit finished, cur_valid, rdy;
      logic [2:0] c_dx, c_dy, c_gx, c_gy;
      logic [15:0] c_ser;

      l = (seed == 16'h0000) ? 16'hACE1 : seed;
      for (int k = 0; k < total; k++) begin
`ifdef TRAFFIC_INJECTOR_LFSR_EN
         exp_idx.push_back(int'(l % 16'(D)));
         l = lfsr_step(l);
`else
         exp_idx.push_back((ts + k) % D);
`endif
      end
      // With ready always high every slot is free: issue on each edge whose
      // window phase falls below rate_num, edge 1 being the first RUN edge.
      n = 1;
      while (iss_edge.size() < total && n < BUDGET) begin
         if (((ph + n - 1) % DEN) < rate) iss_edge.push_back(n);
         n++;
      end
      exp_done = (total == 0) ? 1 : iss_edge[total-1] + 2;

      pkt_total = 16'(total); rate_num = 4'(rate); phase_init = 4'(ph);
      tbl_start = 4'(ts); lfsr_seed = seed; pkt_if.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || pkt_if.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s start: busy=%b done=%b valid=%b required busy=1 done=0 valid=0",
                  name, busy, done, pkt_if.out_valid);
      end

      k_x = 0; k_i = 0; stalls = 0; hold = 0; finished = 0; n = 0;
      while (!finished && n < BUDGET) begin
         n++;
         cur_valid = pkt_if.out_valid;
         c_dx = pkt_if.out_dest_x; c_dy = pkt_if.out_dest_y;
         c_gx = pkt_if.out_gate_x; c_gy = pkt_if.out_gate_y;
         c_ser = pkt_if.out_serial;
         case (mode)
            1: rdy = ($urandom_range(0, 3) != 0);
            2: begin
               rdy = 1'b1;
               if (cur_valid && c_ser == 16'd2 && hold < 3) begin
                  rdy = 1'b0; hold++;
               end
            end
            default: rdy = 1'b1;
         endcase
         pkt_if.out_ready = rdy;
         if (cur_valid && !rdy) stalls++;
         tick();

         if (cur_valid && rdy) begin
            checks++;
            if (k_x >= total) begin
               failures++;
               $display("FAIL %s extra packet: serial=%0d accepted beyond total %0d", name, c_ser, total);
            end else if (c_ser !== 16'(k_x) || c_dx !== m_dx[exp_idx[k_x]] ||
                         c_dy !== m_dy[exp_idx[k_x]] || c_gx !== m_gx[exp_idx[k_x]] ||
                         c_gy !== m_gy[exp_idx[k_x]]) begin
               failures++;
               $display("FAIL %s packet %0d: got serial=%0d dx=%0d dy=%0d gx=%0d gy=%0d required serial=%0d entry %0d (%0d %0d %0d %0d)",
                        name, k_x, c_ser, c_dx, c_dy, c_gx, c_gy, k_x, exp_idx[k_x],
                        m_dx[exp_idx[k_x]], m_dy[exp_idx[k_x]], m_gx[exp_idx[k_x]], m_gy[exp_idx[k_x]]);
            end
            k_x++;
         end else if (cur_valid) begin
            checks++;
            if (pkt_if.out_valid !== 1'b1 || pkt_if.out_serial !== c_ser ||
                pkt_if.out_dest_x !== c_dx || pkt_if.out_dest_y !== c_dy ||
                pkt_if.out_gate_x !== c_gx || pkt_if.out_gate_y !== c_gy) begin
               failures++;
               $display("FAIL %s stall hold: valid=%b serial=%0d required valid=1 serial=%0d with fields unchanged",
                        name, pkt_if.out_valid, pkt_if.out_serial, c_ser);
            end
         end

         if (pkt_if.out_valid && (!cur_valid || rdy)) begin
            if (mode == 0) begin
               checks++;
               if (k_i >= total || iss_edge[k_i] != n) begin
                  failures++;
                  $display("FAIL %s issue timing: issue %0d at edge %0d required edge %0d (total %0d)",
                           name, k_i, n, (k_i < total) ? iss_edge[k_i] : -1, total);
               end
            end
            k_i++;
         end

         if (done) begin
            finished = 1;
            if (mode == 0) begin
               checks++;
               if (n != exp_done) begin
                  failures++;
                  $display("FAIL %s done timing: done at edge %0d required edge %0d", name, n, exp_done);
               end
            end
         end
      end

      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL %s timeout: done not seen within %0d cycles", name, BUDGET);
      end
      checks++;
      if (sent_count !== 16'(total) || k_x != total || stall_count !== 16'(stalls) || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s end: sent_count=%0d seen=%0d stall_count=%0d busy=%b required sent=%0d stall=%0d busy=0",
                  name, sent_count, k_x, stall_count, busy, total, stalls);
      end
      pkt_if.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; start = 1'b0;
      tbl_dest_x = '0; tbl_dest_y = '0; tbl_gate_x = '0; tbl_gate_y = '0;
      pkt_total = '0; rate_num = '0; phase_init = '0; tbl_start = '0; lfsr_seed = '0;
      pkt_if.out_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (pkt_if.out_valid !== 1'b0 || pkt_if.out_dest_x !== 3'd0 || pkt_if.out_dest_y !== 3'd0 ||
          pkt_if.out_gate_x !== 3'd0 || pkt_if.out_gate_y !== 3'd0 || pkt_if.out_serial !== 16'd0 ||
          busy !== 1'b0 || done !== 1'b0 || sent_count !== 16'd0 || stall_count !== 16'd0) begin
         failures++;
         $display("FAIL reset values: valid=%b serial=%0d busy=%b done=%b sent=%0d stall=%0d required all zero",
                  pkt_if.out_valid, pkt_if.out_serial, busy, done, sent_count, stall_count);
      end
      checks++;
      if (pkt_if.out_src_id !== 8'(SID)) begin
         failures++;
         $display("FAIL src_id: got %0d required %0d", pkt_if.out_src_id, SID);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_table_load();
      for (int i = 0; i < D; i++)
         write_entry(i, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      // Indices beyond the table must be dropped.
      write_entry(12, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      write_entry(15, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
   endtask

   task automatic test_burst();
      run(5, 10, 0, 0, 0, 16'($urandom), "burst");
   endtask

   task automatic test_rate();
      run(3, 1, 0, 0, 0, 16'($urandom), "rate_1_of_10");
   endtask

   task automatic test_stall();
      run(5, 10, 0, 0, 2, 16'($urandom), "stall");
      checks++;
      if (stall_count !== 16'd3) begin
         failures++;
         $display("FAIL stall count: got %0d required 3", stall_count);
      end
   endtask

   task automatic test_wrap();
      run(12, 10, 0, 8, 0, 16'($urandom), "table_wrap");
   endtask

   task automatic test_zero_packets();
      run(0, 5, 0, 0, 0, 16'($urandom), "zero_packets");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 6; r++) begin
         run(int'($urandom_range(1, 12)), int'($urandom_range(1, 11)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 9)), int'($urandom_range(0, 1)), 16'($urandom), "random_run");
      end
   endtask

   task automatic test_reset_mid_run();
      int ts;
      logic [15:0] seed;
      ts = int'($urandom_range(0, 9));
      seed = 16'($urandom);
      pkt_total = 16'd5; rate_num = 4'd10; phase_init = 4'd0; tbl_start = 4'(ts);
      lfsr_seed = seed; pkt_if.out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      checks++;
      if (pkt_if.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_run hold: valid=%b required 1", pkt_if.out_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pkt_if.out_valid !== 1'b0 || busy !== 1'b0 || sent_count !== 16'd0 || stall_count !== 16'd0) begin
         failures++;
         $display("FAIL async reset: valid=%b busy=%b sent=%0d stall=%0d required 0 0 0 0",
                  pkt_if.out_valid, busy, sent_count, stall_count);
      end
      tick();
      reset = 1'b0;
      pkt_if.out_ready = 1'b1;
      run(1, 10, 0, ts, 0, seed, "after_reset");
   endtask

   task automatic test_rate_zero_locked();
      int seen_valid;
      pkt_total = 16'd3; rate_num = 4'd0; phase_init = 4'd0; tbl_start = 4'd3;
      lfsr_seed = 16'h1234; pkt_if.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      seen_valid = 0;
      // Table write and a second start while running must both be ignored.
      tbl_we = 1'b1; tbl_addr = 4'd3;
      tbl_dest_x = ~m_dx[3]; tbl_dest_y = ~m_dy[3]; tbl_gate_x = ~m_gx[3]; tbl_gate_y = ~m_gy[3];
      tick();
      tbl_we = 1'b0;
      rate_num = 4'd10; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (pkt_if.out_valid === 1'b1) seen_valid++;
         tick();
      end
      checks++;
      if (seen_valid != 0 || busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL rate_zero: valid cycles=%0d busy=%b done=%b required 0 1 0", seen_valid, busy, done);
      end
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      run(1, 10, 0, 3, 0, 16'h1234, "locked_table");
   endtask

   initial begin
      test_reset();
      test_table_load();
      test_burst();
      test_rate();
      test_stall();
      test_wrap();
      test_zero_packets();
      test_back_to_back();
      test_reset_mid_run();
      test_rate_zero_locked();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
